// File: rtl/multi_voice_psg_if.sv
// multi_voice_psg_if: host register-write bus into the PSG.
interface multi_voice_psg_if #(
    parameter int ADDR_W = 5
);
    logic              write_strobe;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data;
    modport master(output write_strobe, address, data);
    modport slave(input write_strobe, address, data);
endinterface

// File: rtl/multi_voice_psg.sv
// multi_voice_psg: N square-wave voices with decay envelopes, LFSR noise, summing mixer and PWM DAC.
module multi_voice_psg #(
    parameter int NUM_VOICES = 3,
    parameter int PERIOD_W = 12,
    parameter int VOL_W = 4,
    parameter int ENV_DIV = 1024,
    parameter int ADDR_W = 5,
    localparam int MIX_W = VOL_W + $clog2(NUM_VOICES + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_voice_psg_if.slave      bus,
    output logic                  signal_out,
    output logic [MIX_W-1:0]      mix_level,
    output logic [NUM_VOICES-1:0] voice_wave,
    output logic                  noise_out
);
    localparam int ENV_W = ENV_DIV > 1 ? $clog2(ENV_DIV) : 1;
    localparam int NOISE_ADDR = 4 * NUM_VOICES;

    logic [NUM_VOICES-1:0] sel;
    logic [MIX_W-1:0]      term [NUM_VOICES];
    logic [MIX_W-1:0]      mix_sum;
    logic [MIX_W-1:0]      pwm_cnt;
    logic [7:0]            noise_div;
    logic [7:0]            noise_cnt;
    logic [15:0]           lfsr;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++)
            sel[v] = bus.write_strobe && bus.address[ADDR_W-1:2] == (ADDR_W-2)'(v);
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] cnt;
        logic [VOL_W-1:0]    vol;
        logic [VOL_W-1:0]    env_lvl;
        logic [VOL_W-1:0]    eff;
        logic [ENV_W-1:0]    env_pre;
        logic                tone_en;
        logic                noise_en;
        logic                env_en;
        logic                wave;
        logic                trig;
        assign trig = sel[g] && bus.address[1:0] == 2'd3 && bus.data[3];
        assign eff = env_en ? env_lvl : vol;
        assign term[g] = ((tone_en & wave) | (noise_en & lfsr[0])) ? MIX_W'(eff) : '0;
        assign voice_wave[g] = wave & tone_en;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                period   <= '0;
                cnt      <= '0;
                vol      <= '0;
                env_lvl  <= '0;
                env_pre  <= '0;
                tone_en  <= 1'b0;
                noise_en <= 1'b0;
                env_en   <= 1'b0;
                wave     <= 1'b0;
            end else begin
                if (sel[g] && bus.address[1:0] == 2'd0) period[7:0] <= bus.data;
                if (sel[g] && bus.address[1:0] == 2'd1) period[PERIOD_W-1:8] <= bus.data[PERIOD_W-9:0];
                if (sel[g] && bus.address[1:0] == 2'd2) vol <= bus.data[VOL_W-1:0];
                if (sel[g] && bus.address[1:0] == 2'd3) {env_en, noise_en, tone_en} <= bus.data[2:0];
                // compare against the live period so a shortened period toggles at once
                if (tone_en) begin
                    if (period == '0) begin
                        cnt  <= '0;
                        wave <= 1'b0;
                    end else if (cnt >= period) begin
                        cnt  <= '0;
                        wave <= ~wave;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (trig) begin
                    env_lvl <= vol;
                    env_pre <= '0;
                end else if (env_pre == ENV_W'(ENV_DIV - 1)) begin
                    env_pre <= '0;
                    env_lvl <= env_lvl - VOL_W'(env_lvl != '0);
                end else begin
                    env_pre <= env_pre + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) mix_sum = mix_sum + term[v];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noise_div  <= '0;
            noise_cnt  <= '0;
            lfsr       <= 16'hACE1;
            mix_level  <= '0;
            pwm_cnt    <= '0;
            signal_out <= 1'b0;
        end else begin
            if (bus.write_strobe && bus.address == ADDR_W'(NOISE_ADDR)) noise_div <= bus.data;
            if (noise_cnt >= noise_div) begin
                noise_cnt <= '0;
                lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end else begin
                noise_cnt <= noise_cnt + 1'b1;
            end
            mix_level  <= mix_sum;
            pwm_cnt    <= pwm_cnt + 1'b1;
            signal_out <= pwm_cnt < mix_level;
        end
    end

    assign noise_out = lfsr[0];
endmodule

// File: tb/tb_multi_voice_psg.sv
// tb_multi_voice_psg: directed self-checking bench for multi_voice_psg.
module tb_multi_voice_psg;
    localparam int NV = 3;
    localparam int VW = 4;
    localparam int MIX_W = VW + $clog2(NV + 2);
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            signal_out;
    logic            noise_out;
    logic [MIX_W-1:0] mix_level;
    logic [NV-1:0]   voice_wave;
    int checks = 0;
    int errors = 0;

    multi_voice_psg_if #(.ADDR_W(5)) bus ();

    multi_voice_psg #(.NUM_VOICES(NV), .PERIOD_W(12), .VOL_W(VW), .ENV_DIV(4), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .signal_out(signal_out),
        .mix_level(mix_level),
        .voice_wave(voice_wave),
        .noise_out(noise_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.write_strobe = 1'b1;
        bus.address = 5'(a);
        bus.data = 8'(d);
        tick();
        bus.write_strobe = 1'b0;
    endtask

    task automatic half_period(input int b, input int budget, output int n);
        logic p;
        p = voice_wave[b];
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (voice_wave[b] !== p) return;
        end
        n = -1;
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    initial begin
        int n;
        int hi;
        logic seen;
        logic big;
        logic pn;
        logic [15:0] m;
        bus.write_strobe = 1'b0;
        bus.address = '0;
        bus.data = '0;
        tick(3);
        check("reset_noise", noise_out, 1);
        rst = 1'b0;
        check("reset_wave", voice_wave, 0);
        check("reset_mix", mix_level, 0);
        check("reset_pwm", signal_out, 0);

        // asynchronous reset while a write is on the bus
        wr(0, 1);
        wr(3, 1);
        for (int i = 0; i < 4 && !voice_wave[0]; i++) tick();
        check("pre_rst_wave", voice_wave[0], 1);
        bus.write_strobe = 1'b1;
        bus.address = 5'd2;
        bus.data = 8'd5;
        #2 rst = 1'b1;
        #1;
        check("async_rst_wave", voice_wave, 0);
        check("async_rst_mix", mix_level, 0);
        check("async_rst_pwm", signal_out, 0);
        check("async_rst_noise", noise_out, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.write_strobe = 1'b0;
        wr(0, 1);
        wr(3, 1);
        seen = 1'b0;
        big = 1'b0;
        repeat (20) begin
            tick();
            seen |= voice_wave[0];
            big |= (mix_level != 0);
        end
        check("rst_write_dropped", big, 0);
        check("post_rst_tone", seen, 1);

        // tone period 200, then shorten to 3 mid-count
        wr(0, 8'hC8);
        wr(1, 0);
        wr(2, 8);
        half_period(0, 400, n);
        half_period(0, 400, n);
        check("half_200", n, 201);
        tick(145);
        wr(0, 3);
        half_period(0, 10, n);
        check("shorten_next", n, 1);
        half_period(0, 10, n);
        check("half_3", n, 4);

        // full-width period
        wr(1, 8'h0F);
        wr(0, 8'hFF);
        half_period(0, 5000, n);
        half_period(0, 5000, n);
        check("half_fff", n, 4096);

        wr(0, 0);
        wr(1, 0);
        tick(2);
        check("period0_wave", voice_wave[0], 0);
        tick(2);
        check("period0_mix", mix_level, 0);

        // envelope on voice 2
        wr(3, 0);
        wr(8, 8'hFF);
        wr(9, 8'h0F);
        wr(10, 15);
        wr(11, 5);
        half_period(2, 5000, n);
        check("env_wave_up", voice_wave[2], 1);
        check("env_pre_trig", mix_level, 0);
        wr(11, 8'h0D);
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("env_step_%0d", k), mix_level, 15 - k);
            tick(3);
        end
        tick(8);
        check("env_floor", mix_level, 0);
        wr(11, 8'h0D);
        tick(20);
        check("env_mid", mix_level, 11);
        wr(11, 8'h0D);
        tick();
        check("env_retrig", mix_level, 15);
        wr(11, 1);
        tick();
        check("env_off_vol", mix_level, 15);
        wr(11, 0);

        // noise: reset, then noise_div=3 lands on the first edge
        rst = 1'b1;
        bus.write_strobe = 1'b1;
        bus.address = 5'd12;
        bus.data = 8'd3;
        tick(2);
        rst = 1'b0;
        m = 16'hACE1;
        check("noise_seed", noise_out, m[0]);
        tick();
        bus.write_strobe = 1'b0;
        m = lstep(m);
        check("noise_step_0", noise_out, m[0]);
        for (int k = 1; k < 100; k++) begin
            tick(3);
            check($sformatf("noise_hold_%0d", k), noise_out, m[0]);
            tick();
            m = lstep(m);
            check($sformatf("noise_step_%0d", k), noise_out, m[0]);
        end
        wr(6, 4);
        wr(7, 2);
        pn = noise_out;
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("noise_mix_%0d", k), mix_level, pn ? 4 : 0);
            pn = noise_out;
        end

        // full-scale mixer and PWM duty
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int v = 0; v < NV; v++) begin
            wr(4 * v, 8'hFF);
            wr(4 * v + 1, 8'h0F);
            wr(4 * v + 2, 15);
        end
        wr(3, 1);
        wr(7, 1);
        wr(11, 1);
        for (int i = 0; i < 5000 && voice_wave != 3'b111; i++) tick();
        check("all_high", voice_wave, 7);
        tick();
        check("mix_full", mix_level, 45);
        hi = 0;
        repeat (1 << MIX_W) begin
            tick();
            hi += int'(signal_out);
        end
        check("pwm_duty", hi, 45);
        wr(3, 0);
        wr(7, 0);
        wr(11, 0);
        tick(3);
        check("mix_off", mix_level, 0);
        hi = 0;
        repeat (1 << MIX_W) begin
            tick();
            hi += int'(signal_out);
        end
        check("pwm_off", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
